// File: rtl/ram_sp_burst_master.sv
// Burst controller for a single-port synchronous RAM with a shared tri-state
// data bus. It takes read/write burst commands over valid/ready, walks the
// RAM address upward one word per cycle, streams write data out and read data
// back, and inserts a dead cycle after every read. That dead cycle stops the
// RAM and the controller from ever driving the data bus at the same time.

module ram_sp_burst_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    // write data channel
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // read data channel (no backpressure)
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    // status
    output logic                  busy,
    // RAM side
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        READ       = 3'd2,
        READ_DRAIN = 3'd3,
        TURN       = 3'd4
    } state_t;

    // Address step within a burst; overflow wraps silently to address 0.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        next_addr = a + ADDR_WIDTH'(1);
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [ADDR_WIDTH-1:0]  addr_s;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [LEN_WIDTH-1:0]   cnt_s;
    // High in the cycle after a READ address was presented: the RAM is then
    // driving the word for that address on the bus.
    logic                   rd_pending_r;
    logic                   rd_valid_r;
    logic [DATA_WIDTH-1:0]  rd_data_r;

    logic                   cmd_ready_s;
    logic                   wr_ready_s;
    logic                   cs_s;
    logic                   we_s;
    logic                   oe_s;
    logic                   drive_s;
    logic                   busy_s;
    logic [ADDR_WIDTH-1:0]  ram_address_s;

    // Next-state, counter updates and combinational RAM/handshake outputs.
    always_comb begin
        state_s       = state_r;
        addr_s        = addr_r;
        cnt_s         = cnt_r;
        cmd_ready_s   = 1'b0;
        wr_ready_s    = 1'b0;
        cs_s          = 1'b0;
        we_s          = 1'b0;
        oe_s          = 1'b0;
        drive_s       = 1'b0;
        busy_s        = 1'b1;
        ram_address_s = '0;

        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
                busy_s      = 1'b0;
                if (cmd_valid) begin
                    addr_s  = cmd_addr;
                    cnt_s   = cmd_len;
                    state_s = cmd_write ? WRITE : READ;
                end else begin
                    state_s = IDLE;
                end
            end

            WRITE: begin
                // The controller owns the bus for the whole burst; the RAM
                // only sees a cycle when a word is actually offered.
                wr_ready_s    = 1'b1;
                drive_s       = 1'b1;
                cs_s          = wr_valid;
                we_s          = wr_valid;
                ram_address_s = addr_r;
                if (wr_valid) begin
                    if (cnt_r == '0) begin
                        state_s = IDLE;
                    end else begin
                        addr_s = next_addr(addr_r);
                        cnt_s  = cnt_r - LEN_WIDTH'(1);
                    end
                end else begin
                    state_s = WRITE;
                end
            end

            READ: begin
                cs_s          = 1'b1;
                oe_s          = 1'b1;
                ram_address_s = addr_r;
                if (cnt_r == '0) begin
                    // Hold the last address so the drain cycle reads the same word.
                    state_s = READ_DRAIN;
                end else begin
                    addr_s = next_addr(addr_r);
                    cnt_s  = cnt_r - LEN_WIDTH'(1);
                end
            end

            READ_DRAIN: begin
                cs_s          = 1'b1;
                oe_s          = 1'b1;
                ram_address_s = addr_r;
                state_s       = TURN;
            end

            TURN: begin
                // Dead cycle: RAM output disabled, controller not yet driving.
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        // Reset releases the bus and drops every strobe in the same cycle.
        if (rst) begin
            cmd_ready_s   = 1'b0;
            wr_ready_s    = 1'b0;
            cs_s          = 1'b0;
            we_s          = 1'b0;
            oe_s          = 1'b0;
            drive_s       = 1'b0;
            busy_s        = 1'b0;
            ram_address_s = '0;
            state_s       = IDLE;
        end else begin
            busy_s = busy_s;
        end
    end

    // State, address/length counters and read capture pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            cnt_r        <= '0;
            rd_pending_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= '0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            cnt_r        <= cnt_s;
            rd_pending_r <= (state_r == READ);
            rd_valid_r   <= rd_pending_r;
            if (rd_pending_r) begin
                rd_data_r <= ram_data;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign ram_data    = drive_s ? wr_data : {DATA_WIDTH{1'bz}};
    assign cmd_ready   = cmd_ready_s;
    assign wr_ready    = wr_ready_s;
    assign ram_cs      = cs_s;
    assign ram_we      = we_s;
    assign ram_oe      = oe_s;
    assign busy        = busy_s;
    assign ram_address = ram_address_s;
    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;

    ram_sp_burst_master_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .cmd_ready (cmd_ready_s),
        .busy      (busy_s),
        .wr_ready  (wr_ready_s),
        .drive     (drive_s),
        .ram_cs    (cs_s),
        .ram_we    (we_s),
        .ram_oe    (oe_s),
        .rd_valid  (rd_valid_r)
    );

endmodule

// Protocol properties of the controller's RAM and handshake outputs.
module ram_sp_burst_master_checker (
    input logic clk,
    input logic rst,
    input logic cmd_ready,
    input logic busy,
    input logic wr_ready,
    input logic drive,
    input logic ram_cs,
    input logic ram_we,
    input logic ram_oe
    ,
    input logic rd_valid
);

    // Output enable and write enable are mutually exclusive.
    a_oe_we_excl: assert property (@(posedge clk) !(ram_oe && ram_we));

    // The controller never drives the bus while the RAM output is enabled.
    a_no_contention: assert property (@(posedge clk) !(drive && ram_oe));

    // Writes always carry chip select.
    a_we_has_cs: assert property (@(posedge clk) ram_we |-> ram_cs);

    // Write acceptance only happens while the controller owns the bus.
    a_wr_ready_drive: assert property (@(posedge clk) wr_ready |-> drive);

    // Command acceptance only while not busy.
    a_ready_not_busy: assert property (@(posedge clk) !(cmd_ready && busy));

    // No read strobe survives past a reset cycle.
    a_rst_kills_rd: assert property (@(posedge clk) rst |=> !rd_valid);

endmodule

// File: tb/tb_ram_sp_burst_master.sv
// Self-checking bench for ram_sp_burst_master: a behavioural RAM on the shared
// bus, a reference memory image plus expected-write/expected-read queues, and
// directed timing checks followed by randomized bursts.

module tb_ram_sp_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       cmd_ready;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] ram_address;
    wire  [7:0] ram_data;
    logic       ram_cs, ram_we, ram_oe;

    int tests = 0;
    int fails = 0;

    // RAM model (device side) and reference image (expected contents).
    logic [7:0]  mem [256];
    logic [7:0]  ram_q;
    logic        init_mem;
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_wq [$];
    logic [7:0]  exp_rq [$];
    logic [7:0]  wq [$];
    int          write_count = 0;

    ram_sp_burst_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered read, output driven while cs&oe&!we.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else begin
            if (ram_cs && ram_we) mem[ram_address] <= ram_data;
            if (ram_cs && !ram_we) ram_q <= mem[ram_address];
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'bzzzzzzzz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and bus-protocol monitor.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("oe_we_excl", 32'(ram_oe & ram_we), 32'd0);
            check_eq("bus_contention", 32'(wr_ready & ram_oe), 32'd0);
            if (ram_cs && ram_we) begin
                write_count++;
                if (exp_wq.size() == 0) begin
                    check_eq("unexpected_write", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_wq.pop_front();
                    check_eq("wr_addr", 32'(ram_address), 32'(e[15:8]));
                    check_eq("wr_data", 32'(ram_data), 32'(e[7:0]));
                end
            end
            if (rd_valid) begin
                if (exp_rq.size() == 0) begin
                    check_eq("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    check_eq("rd_data", 32'(rd_data), 32'(exp_rq.pop_front()));
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // gap: 0 none, 1 two idle cycles before the second word, 2 random idles.
    task automatic do_write(input logic [7:0] a, input logic [7:0] l, input int gap, input bit skip_cmd);
        logic [7:0] dl [$];
        int         ng;
        int         start;
        bit         ok;
        for (int i = 0; i <= int'(l); i++) begin
            if (wq.size() > 0) dl.push_back(wq.pop_front());
            else dl.push_back(8'($urandom));
            exp_wq.push_back({8'(a + i), dl[i]});
            ref_mem[8'(a + i)] = dl[i];
        end
        start = write_count;
        if (!skip_cmd) send_cmd(1'b1, a, l);
        else cmd_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            ng = (gap == 1) ? ((i == 1) ? 2 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                wr_valid = 1'b0;
                @(negedge clk);
                check_eq("gap_cs", 32'(ram_cs), 32'd0);
                check_eq("gap_addr", 32'(ram_address), 32'(8'(a + i)));
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = dl[i];
            ok       = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (wr_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!ok) check_eq("wr_ready_timeout", 32'd0, 32'd1);
            check_eq("wr_cs", 32'(ram_cs), 32'd1);
            check_eq("wr_oe", 32'(ram_oe), 32'd0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check_eq("wr_done_busy", 32'(busy), 32'd0);
        check_eq("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("wr_count", 32'(write_count - start), 32'(int'(l) + 1));
        @(posedge clk); #1;
    endtask

    // timed: check the per-cycle read timeline; pend: hold a write command
    // (pa, pl) pending during the read so it is accepted right after TURN.
    task automatic do_read(input logic [7:0] a, input logic [7:0] l, input bit timed,
                           input bit pend, input logic [7:0] pa, input logic [7:0] pl);
        int  n;
        bit  ok;
        n = int'(l) + 1;
        for (int i = 0; i < n; i++) exp_rq.push_back(ref_mem[8'(a + i)]);
        send_cmd(1'b0, a, l);
        if (pend) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = pa;
            cmd_len   = pl;
        end
        if (timed) begin
            for (int c = 1; c <= n + 3; c++) begin
                @(negedge clk);
                check_eq("t_oe", 32'(ram_oe), 32'(c <= n + 1));
                check_eq("t_cs", 32'(ram_cs), 32'(c <= n + 1));
                check_eq("t_we", 32'(ram_we), 32'd0);
                check_eq("t_wr_ready", 32'(wr_ready), 32'd0);
                check_eq("t_rd_valid", 32'(rd_valid), 32'(c >= 3 && c <= n + 2));
                check_eq("t_cmd_ready", 32'(cmd_ready), 32'(c == n + 3));
                check_eq("t_busy", 32'(busy), 32'(c <= n + 2));
                @(posedge clk); #1;
            end
        end else begin
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!busy && exp_rq.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check_eq("rd_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'd0; cmd_len = 8'd0;
        wr_valid = 1'b0; wr_data = 8'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        @(posedge clk); #1;
        init_mem = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_ctl", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
        check_eq("rst_addr", 32'(ram_address), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Continuous write then timed read-back.
        wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_write(8'h10, 8'd3, 0, 1'b0);
        do_read(8'h10, 8'd3, 1'b1, 1'b0, 8'd0, 8'd0);

        // Write with wr_valid pattern 1,0,0,1,1.
        do_write(8'h40, 8'd2, 1, 1'b0);
        do_read(8'h40, 8'd2, 1'b0, 1'b0, 8'd0, 8'd0);

        // Address wrap.
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(8'hFE, 8'd3, 0, 1'b0);
        do_read(8'hFE, 8'd3, 1'b0, 1'b0, 8'd0, 8'd0);

        // Single-word read with a write command already pending.
        do_read(8'h41, 8'd0, 1'b1, 1'b1, 8'h80, 8'd2);
        do_write(8'h80, 8'd2, 0, 1'b1);
        do_read(8'h80, 8'd2, 1'b0, 1'b0, 8'd0, 8'd0);

        // Reset in cycle 2 of an eight-word read.
        for (int i = 0; i < 8; i++) exp_rq.push_back(ref_mem[8'(8'h20 + i)]);
        send_cmd(1'b0, 8'h20, 8'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_rq.delete();
        @(negedge clk);
        check_eq("mid_rst_ctl", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("post_rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        do_read(8'h20, 8'd7, 1'b1, 1'b0, 8'd0, 8'd0);

        // Randomized bursts.
        for (int t = 0; t < 24; t++) begin
            logic [7:0] ra, rl;
            ra = 8'($urandom);
            rl = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) do_write(ra, rl, 2, 1'b0);
            else do_read(ra, rl, 1'b0, 1'b0, 8'd0, 8'd0);
        end

        check_eq("exp_wq_empty", 32'(exp_wq.size()), 32'd0);
        check_eq("exp_rq_empty", 32'(exp_rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
